// File: rtl/affine_sequencer_if.sv
// Interface: affine_sequencer_if
// Groups the operator-facing signals of the affine sequencer.
//   sw_data      signed operand from the switches
//   sw_strobe    switch strobe, asynchronous to the block clock
//   led          signed result display
//   ready        sequencer is waiting for an operand
//   busy         sequencer is computing
//   result_valid led shows x2 or y2
//   state_dbg    encoded FSM state, for observation only
//   ovf          (AFFINE_SAT_EN builds only) a displayed result was clipped
// Modports: master drives the switches, slave is the sequencer.
interface affine_sequencer_if #(
    parameter int N = 8
);
    logic signed [N-1:0] sw_data;
    logic                sw_strobe;
    logic signed [N-1:0] led;
    logic                ready;
    logic                busy;
    logic                result_valid;
    logic [2:0]          state_dbg;
`ifdef AFFINE_SAT_EN
    logic                ovf;

    modport master (
        output sw_data, sw_strobe,
        input  led, ready, busy, result_valid, state_dbg, ovf
    );
    modport slave (
        input  sw_data, sw_strobe,
        output led, ready, busy, result_valid, state_dbg, ovf
    );
`else
    modport master (
        output sw_data, sw_strobe,
        input  led, ready, busy, result_valid, state_dbg
    );
    modport slave (
        input  sw_data, sw_strobe,
        output led, ready, busy, result_valid, state_dbg
    );
`endif
endinterface

// File: rtl/affine_sequencer.sv
// Module: affine_sequencer
// Controller for the picoMIPS affine-transform datapath. Captures x1 then y1
// from the switches and computes
//   x2 = B1 + A11*x1 + A12*y1,  y2 = B2 + A21*x1 + A22*y1
// with one time-shared signed multiplier (four product cycles), then shows
// x2 and afterwards y2 on the LEDs.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    affine_sequencer_if.slave (switches in, led/status out)
// Handshake: the strobe is a level handshake. A waiting state (ready=1) takes
// the operand when the synchronised strobe is 1 and then waits for it to
// return to 0 before asking for the next operand. The result states
// (result_valid=1) advance from x2 to y2 on strobe=1 and back to operand
// capture on strobe=0. sw_data must be stable >=3 clk before the strobe rises.
// Build option: define AFFINE_SAT_EN to saturate displayed results and add
// the ovf flag; otherwise results wrap to N bits.
module affine_sequencer #(
    parameter int N    = 8,
    parameter int FRAC = 7,
    parameter int A11  = 96,
    parameter int A12  = 64,
    parameter int A21  = -64,
    parameter int A22  = 96,
    parameter int B1   = 5,
    parameter int B2   = 12
) (
    input  logic               clk,
    input  logic               reset,
    affine_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_GET_X   = 3'd0,
        S_REL_X   = 3'd1,
        S_GET_Y   = 3'd2,
        S_REL_Y   = 3'd3,
        S_COMPUTE = 3'd4,
        S_SHOW_X  = 3'd5,
        S_SHOW_Y  = 3'd6
    } state_t;

    localparam logic signed [N-1:0] C11 = N'(A11);
    localparam logic signed [N-1:0] C12 = N'(A12);
    localparam logic signed [N-1:0] C21 = N'(A21);
    localparam logic signed [N-1:0] C22 = N'(A22);
    localparam logic signed [N+2:0] OFS_X = (N+3)'(B1);
    localparam logic signed [N+2:0] OFS_Y = (N+3)'(B2);
    localparam logic signed [N+2:0] ACC_MAX = (N+3)'((2 ** (N-1)) - 1);
    localparam logic signed [N+2:0] ACC_MIN = (N+3)'(-(2 ** (N-1)));

    state_t              state, state_next;
    logic                sync0, sync1, s;
    logic signed [N-1:0] x1, y1, led_q;
    logic signed [N+2:0] acc_x, acc_y;
    logic [1:0]          step;
    logic signed [N-1:0] coef, operand;
    logic signed [2*N-1:0] product, shifted;
    logic signed [N+2:0] term;

    // Accumulator to display width.
    function automatic logic signed [N-1:0] fmt(input logic signed [N+2:0] a);
`ifdef AFFINE_SAT_EN
        if (a > ACC_MAX)      return N'(ACC_MAX);
        else if (a < ACC_MIN) return N'(ACC_MIN);
        else                  return N'(a);
`else
        return N'(a);
`endif
    endfunction

`ifdef AFFINE_SAT_EN
    logic ovf_q;
    function automatic logic clips(input logic signed [N+2:0] a);
        return (a > ACC_MAX) || (a < ACC_MIN);
    endfunction
    assign bus.ovf = ovf_q;
`endif

    // Two-flop synchroniser for the asynchronous strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= bus.sw_strobe;
            sync1 <= sync0;
        end
    end
    assign s = sync1;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_GET_X;
        else       state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            S_GET_X:   if (s)             state_next = S_REL_X;
            S_REL_X:   if (!s)            state_next = S_GET_Y;
            S_GET_Y:   if (s)             state_next = S_REL_Y;
            S_REL_Y:   if (!s)            state_next = S_COMPUTE;
            S_COMPUTE: if (step == 2'd3)  state_next = S_SHOW_X;
            S_SHOW_X:  if (s)             state_next = S_SHOW_Y;
            S_SHOW_Y:  if (!s)            state_next = S_GET_X;
            default:                      state_next = S_GET_X;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.ready        = (state == S_GET_X) || (state == S_GET_Y);
        bus.busy         = (state == S_COMPUTE);
        bus.result_valid = (state == S_SHOW_X) || (state == S_SHOW_Y);
    end
    assign bus.state_dbg = state;
    assign bus.led       = led_q;

    // Shared multiplier: steps 0/2 use x1, steps 1/3 use y1.
    always_comb begin
        case (step)
            2'd0:    begin coef = C11; operand = x1; end
            2'd1:    begin coef = C12; operand = y1; end
            2'd2:    begin coef = C21; operand = x1; end
            default: begin coef = C22; operand = y1; end
        endcase
    end
    assign product = coef * operand;
    // Arithmetic shift floors toward minus infinity.
    assign shifted = product >>> FRAC;
    assign term    = (N+3)'(shifted);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x1    <= '0;
            y1    <= '0;
            acc_x <= '0;
            acc_y <= '0;
            step  <= '0;
            led_q <= '0;
`ifdef AFFINE_SAT_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_GET_X: if (s) x1 <= bus.sw_data;
                S_GET_Y: if (s) y1 <= bus.sw_data;
                S_REL_Y: if (!s) begin
                    acc_x <= OFS_X;
                    acc_y <= OFS_Y;
                    step  <= 2'd0;
`ifdef AFFINE_SAT_EN
                    ovf_q <= 1'b0;
`endif
                end
                S_COMPUTE: begin
                    step <= step + 2'd1;
                    if (step[1]) acc_y <= acc_y + term;
                    else         acc_x <= acc_x + term;
                    // acc_x is final once steps 0 and 1 are done.
                    if (step == 2'd3) begin
                        led_q <= fmt(acc_x);
`ifdef AFFINE_SAT_EN
                        if (clips(acc_x)) ovf_q <= 1'b1;
`endif
                    end
                end
                S_SHOW_X: if (s) begin
                    led_q <= fmt(acc_y);
`ifdef AFFINE_SAT_EN
                    if (clips(acc_y)) ovf_q <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_affine_sequencer.sv
module tb_affine_sequencer;
    localparam int N = 8;
    localparam logic [2:0] ST_GET_X   = 3'd0;
    localparam logic [2:0] ST_REL_X   = 3'd1;
    localparam logic [2:0] ST_GET_Y   = 3'd2;
    localparam logic [2:0] ST_REL_Y   = 3'd3;
    localparam logic [2:0] ST_COMPUTE = 3'd4;
    localparam logic [2:0] ST_SHOW_X  = 3'd5;
    localparam logic [2:0] ST_SHOW_Y  = 3'd6;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   busy_cnt;

    always #5 clk = ~clk;

    affine_sequencer_if #(.N(N)) bus();

    affine_sequencer #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait; an expired bound shows up as a failed state comparison.
    task automatic wait_state(input logic [2:0] target, input string tag);
        int k = 0;
        while (bus.state_dbg !== target && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(bus.state_dbg), 32'(target));
    endtask

    // Full operand handshake; returns at the first busy cycle.
    task automatic load_operands(input logic signed [N-1:0] x,
                                 input logic signed [N-1:0] y, input string tag);
        bus.sw_data = x;
        tick(3);
        bus.sw_strobe = 1'b1;
        wait_state(ST_REL_X, {tag, "_rel_x"});
        bus.sw_strobe = 1'b0;
        wait_state(ST_GET_Y, {tag, "_get_y"});
        bus.sw_data = y;
        tick(3);
        bus.sw_strobe = 1'b1;
        wait_state(ST_REL_Y, {tag, "_rel_y"});
        bus.sw_strobe = 1'b0;
        wait_state(ST_COMPUTE, {tag, "_compute"});
    endtask

    task automatic show_results(input int ex, input int ey, input string tag);
        wait_state(ST_SHOW_X, {tag, "_show_x"});
        check({tag, "_led_x2"}, 32'(bus.led), ex);
        check({tag, "_valid"}, 32'(bus.result_valid), 1);
        bus.sw_strobe = 1'b1;
        wait_state(ST_SHOW_Y, {tag, "_show_y"});
        check({tag, "_led_y2"}, 32'(bus.led), ey);
        bus.sw_strobe = 1'b0;
        wait_state(ST_GET_X, {tag, "_back_get_x"});
        check({tag, "_led_hold"}, 32'(bus.led), ey);
        check({tag, "_ready"}, 32'(bus.ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        reset = 1'b1;
        bus.sw_data = '0;
        bus.sw_strobe = 1'b0;
        tick(2);
        check("rst_state", 32'(bus.state_dbg), 32'(ST_GET_X));
        check("rst_led", 32'(bus.led), 0);
        check("rst_ready", 32'(bus.ready), 1);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_valid", 32'(bus.result_valid), 0);
`ifdef AFFINE_SAT_EN
        check("rst_ovf", 32'(bus.ovf), 0);
`endif
        reset = 1'b0;
        tick(2);

        // T1: 25/78 -> 62/57
        load_operands(8'sd25, 8'sd78, "t1");
        show_results(62, 57, "t1");

        // T2: idle clocks keep the FSM waiting, then -32/6 -> -16/32
        tick(6);
        check("t2_idle_state", 32'(bus.state_dbg), 32'(ST_GET_X));
        check("t2_idle_ready", 32'(bus.ready), 1);
        check("t2_idle_busy", 32'(bus.busy), 0);
        load_operands(-8'sd32, 8'sd6, "t2");
        show_results(-16, 32, "t2");

        // T3: floor rounding, 45/-65 -> 5/-60
        load_operands(8'sd45, -8'sd65, "t3");
        show_results(5, -60, "t3");

        // T4: overflow, 127/127
        load_operands(8'sd127, 8'sd127, "t4");
`ifdef AFFINE_SAT_EN
        show_results(127, 43, "t4");
        check("t4_ovf", 32'(bus.ovf), 1);
`else
        show_results(-93, 43, "t4");
`endif

        // T5: strobe toggles during compute; busy lasts exactly 4 clk
        load_operands(8'sd45, -8'sd65, "t5");
        busy_cnt = 0;
        bus.sw_strobe = 1'b1;
        while (bus.busy === 1'b1 && busy_cnt < 10) begin
            busy_cnt++;
            @(negedge clk);
            if (busy_cnt == 1) bus.sw_strobe = 1'b0;
        end
        check("t5_busy_cycles", busy_cnt, 4);
        check("t5_state_show_x", 32'(bus.state_dbg), 32'(ST_SHOW_X));
        check("t5_led_x2_early", 32'(bus.led), 5);
`ifdef AFFINE_SAT_EN
        check("t5_ovf_cleared", 32'(bus.ovf), 0);
`endif
        tick(3);
        check("t5_show_x_holds", 32'(bus.state_dbg), 32'(ST_SHOW_X));
        show_results(5, -60, "t5");

        // T6: reset in the middle of a computation
        load_operands(8'sd25, 8'sd78, "t6");
        tick(1);
        reset = 1'b1;
        tick(1);
        check("t6_rst_led", 32'(bus.led), 0);
        check("t6_rst_state", 32'(bus.state_dbg), 32'(ST_GET_X));
        check("t6_rst_busy", 32'(bus.busy), 0);
        check("t6_rst_ready", 32'(bus.ready), 1);
        reset = 1'b0;
        tick(2);
        load_operands(8'sd25, 8'sd78, "t6b");
        show_results(62, 57, "t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
